// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Asynchronous serial receiver. Recovers 8-bit frames (1 start bit, 8 data bits
// LSB first, optional even parity bit, 1 stop bit) from the idle-high rx line
// using a 16x oversampling tick derived from the system clock.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   - a parity bit follows the data bits and even parity is checked
//   undefined - 10-bit frames, parity_err is tied low
//
// Parameters:
//   CLK_FREQ   - system clock frequency in Hz
//   BAUD       - line rate in bits/s
//   OVERSAMPLE - ticks per bit (only 16 is supported)
//
// Ports:
//   clk        - system clock, all logic on posedge
//   rst        - asynchronous active-high reset
//   rx         - serial input, asynchronous to clk, idle high
//   rx_data    - last good byte, held until the next good byte arrives
//   rx_valid   - one-cycle pulse, rx_data updated this cycle
//   frame_err  - one-cycle pulse, stop bit sampled low
//   parity_err - one-cycle pulse, parity mismatch
//   busy       - high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    // Clocks per oversampling tick, truncated.
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [DW-1:0] DIV_ZERO = DW'(0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY = 3'd5
`endif
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity holds when the data bits and the parity bit XOR to zero.
    function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
        even_parity_ok = ~((^data) ^ par);
    endfunction
`endif

    // Synchronizer and line
    logic          sync1_r;
    logic          rx_s;

    // Timing
    logic [DW-1:0] div_cnt_r;
    logic          tick_s;
    logic [3:0]    sc_r;
    logic          mid_s;

    // Frame datapath
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          par_ok_s;
`ifdef UART_RX_PARITY_EN
    logic          par_bit_r;
    logic          perr_nxt_s;
    logic          parity_err_r;
`endif

    // FSM
    state_t        state_r;
    state_t        state_nxt_s;
    logic          valid_nxt_s;
    logic          ferr_nxt_s;

    // Registered outputs
    logic [7:0]    rx_data_r;
    logic          rx_valid_r;
    logic          frame_err_r;
    logic          busy_r;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_r <= rx;
            rx_s    <= sync1_r;
        end
    end

    assign tick_s = (div_cnt_r == DIV_LAST);
    // Mid-bit sample point: eighth tick of every 16-tick bit period.
    assign mid_s  = tick_s && (sc_r == 4'd7);

    // Tick divider; parked at zero while waiting so bit timing aligns to the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= DIV_ZERO;
        end else if ((state_r == ST_IDLE) || (state_r == ST_BREAK)) begin
            div_cnt_r <= DIV_ZERO;
        end else if (tick_s) begin
            div_cnt_r <= DIV_ZERO;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
        end
    end

    // Oversample counter. It keeps running across bit boundaries (wrapping 15->0),
    // so consecutive mid-bit samples stay exactly 16 ticks apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_r <= 4'd0;
        end else if ((state_r == ST_IDLE) || (state_r == ST_BREAK)) begin
            sc_r <= 4'd0;
        end else if (tick_s) begin
            sc_r <= sc_r + 4'd1;
        end else begin
            sc_r <= sc_r;
        end
    end

    // Data bit index; restarts at zero whenever the receiver is outside DATA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx_r <= 3'd0;
        end else if (state_r != ST_DATA) begin
            bit_idx_r <= 3'd0;
        end else if (mid_s) begin
            bit_idx_r <= bit_idx_r + 3'd1;
        end else begin
            bit_idx_r <= bit_idx_r;
        end
    end

    // Shift register: LSB arrives first, so each sample enters at bit 7 and moves right.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= 8'h00;
        end else if ((state_r == ST_DATA) && mid_s) begin
            shift_r <= {rx_s, shift_r[7:1]};
        end else begin
            shift_r <= shift_r;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Captured parity bit of the current frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit_r <= 1'b0;
        end else if ((state_r == ST_PARITY) && mid_s) begin
            par_bit_r <= rx_s;
        end else begin
            par_bit_r <= par_bit_r;
        end
    end

    assign par_ok_s = even_parity_ok(shift_r, par_bit_r);
`else
    assign par_ok_s = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and next values of the pulse outputs.
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = 1'b0;
        ferr_nxt_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_nxt_s  = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (mid_s) begin
                    // A line back high at mid-start was a glitch: drop it silently.
                    if (rx_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (mid_s && (bit_idx_r == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt_s = ST_PARITY;
`else
                    state_nxt_s = ST_STOP;
`endif
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (mid_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (mid_s) begin
                    if (rx_s) begin
                        // Returning to IDLE at mid-stop lets a start edge in the
                        // second half of the stop bit begin the next frame.
                        state_nxt_s = ST_IDLE;
                        if (par_ok_s) begin
                            valid_nxt_s = 1'b1;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            perr_nxt_s  = 1'b1;
`else
                            valid_nxt_s = 1'b0;
`endif
                        end
                    end else begin
                        // A low stop bit may be a held-low line; BREAK waits it out.
                        state_nxt_s = ST_BREAK;
                        ferr_nxt_s  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_nxt_s  = ~par_ok_s;
`endif
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BREAK;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output registers: pulses last one cycle, rx_data only moves on a good frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rx_valid_r  <= valid_nxt_s;
            frame_err_r <= ferr_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            if (valid_nxt_s) begin
                rx_data_r <= shift_r;
            end else begin
                rx_data_r <= rx_data_r;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity error pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= perr_nxt_s;
        end
    end

    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Bench for uart_rx with CLK_FREQ=16_000 and BAUD=100 (10 clocks per tick,
// 160 clocks per bit). A bit-banger drives rx; for each frame a frame-level
// model decides which pulse the receiver owes and queues it. An independent
// monitor pops that queue whenever any output pulse appears.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT_CLKS = 160;

    typedef struct packed {
        logic       v;
        logic       f;
        logic       p;
        logic [7:0] d;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int   checks;
    int   errors;
    ev_t  exp_q[$];
    logic [7:0] last_good;

    uart_rx #(
        .CLK_FREQ  (16_000),
        .BAUD      (100),
        .OVERSAMPLE(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Frame-level model: what the receiver owes for one transmitted frame.
    task automatic expect_frame(input logic [7:0] data, input logic stop_level, input logic par_bit);
        ev_t  e;
        logic par_good;
`ifdef UART_RX_PARITY_EN
        par_good = (((^data) ^ par_bit) == 1'b0);
`else
        par_good = 1'b1;
`endif
        if (stop_level && par_good) begin
            e = '{v: 1'b1, f: 1'b0, p: 1'b0, d: data};
            last_good = data;
        end else if (stop_level) begin
            e = '{v: 1'b0, f: 1'b0, p: 1'b1, d: last_good};
        end else begin
            e = '{v: 1'b0, f: 1'b1, p: ~par_good, d: last_good};
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic level, input int n);
        rx = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_level, input logic par_bit,
                              input int stop_len, input int low_hold, input int gap);
        expect_frame(data, stop_level, par_bit);
        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            drive(data[i], BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        drive(par_bit, BIT_CLKS);
`endif
        drive(stop_level, stop_len);
        if (!stop_level) begin
            drive(1'b0, low_hold);
        end
        drive(1'b1, gap);
    endtask

    task automatic send_good(input logic [7:0] data, input int gap);
        send_frame(data, 1'b1, ^data, BIT_CLKS, 0, gap);
    endtask

    // Monitor: every output pulse must match the oldest owed event.
    always @(negedge clk) begin
        if (!rst && (rx_valid || frame_err || parity_err)) begin
            ev_t obs;
            ev_t exp_e;
            obs = '{v: rx_valid, f: frame_err, p: parity_err, d: rx_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got v=%0b f=%0b p=%0b data=%02h, expected no pulse",
                         obs.v, obs.f, obs.p, obs.d);
            end else begin
                exp_e = exp_q.pop_front();
                if (obs !== exp_e) begin
                    errors++;
                    $display("FAIL pulse: got v=%0b f=%0b p=%0b data=%02h, expected v=%0b f=%0b p=%0b data=%02h",
                             obs.v, obs.f, obs.p, obs.d, exp_e.v, exp_e.f, exp_e.p, exp_e.d);
                end
            end
        end
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #900_000_000;
        $display("FAIL watchdog: got timeout, expected simulation end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        last_good = 8'h00;
        rst       = 1'b1;
        rx        = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_pulses", {29'd0, rx_valid, frame_err, parity_err}, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;
        drive(1'b1, 50);

        // Two frames with a one-bit idle gap; busy must be low inside the gap.
        send_good(8'h55, 80);
        check("busy_gap", {31'd0, busy}, 32'h0);
        drive(1'b1, 80);
        send_good(8'hA3, 100);
        check("data_after_a3", {24'd0, rx_data}, 32'hA3);

        // False start: 40 clocks low, abandoned at mid-start.
        drive(1'b0, 40);
        drive(1'b1, 10);
        check("false_start_busy", {31'd0, busy}, 32'h1);
        drive(1'b1, 150);
        check("false_start_idle", {31'd0, busy}, 32'h0);
        check("false_start_data", {24'd0, rx_data}, 32'hA3);

        // Framing error with the line held low afterwards.
        send_frame(8'h3C, 1'b0, ^8'h3C, BIT_CLKS, 500, 0);
        check("break_busy", {31'd0, busy}, 32'h1);
        check("ferr_data_held", {24'd0, rx_data}, 32'hA3);
        drive(1'b1, 20);
        check("break_release", {31'd0, busy}, 32'h0);
        send_good(8'h81, 40);
        check("data_after_break", {24'd0, rx_data}, 32'h81);

        // Reset midway through bit 4 of 0xF0.
        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, BIT_CLKS);
        end
        drive(1'b1, 80);
        rst = 1'b1;
        #1;
        check("midframe_rst_data", {24'd0, rx_data}, 32'h00);
        check("midframe_rst_busy", {31'd0, busy}, 32'h0);
        check("midframe_rst_pulses", {29'd0, rx_valid, frame_err, parity_err}, 32'h0);
        exp_q.delete();
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 2 * BIT_CLKS);
        send_good(8'h0F, 40);
        check("data_after_rst", {24'd0, rx_data}, 32'h0F);

`ifdef UART_RX_PARITY_EN
        // Explicit parity cases for 0x07 (three ones: parity bit 1 is even).
        send_frame(8'h07, 1'b1, 1'b1, BIT_CLKS, 0, 40);
        send_frame(8'h07, 1'b1, 1'b0, BIT_CLKS, 0, 40);
`endif

        // Shortened stop bit followed immediately by the next start bit.
        send_frame(8'h5A, 1'b1, ^8'h5A, 90, 0, 0);
        send_good(8'hC6, 40);
        check("data_after_short_stop", {24'd0, rx_data}, 32'hC6);

        // Random frames: random data, random gaps, occasional bad stop or parity.
        for (int n = 0; n < 8; n++) begin
            logic [7:0] d;
            logic       stop_ok;
            logic       par;
            d       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 5) != 0);
            par     = ^d;
`ifdef UART_RX_PARITY_EN
            if ($urandom_range(0, 3) == 0) begin
                par = ~par;
            end
`endif
            send_frame(d, stop_ok, par, BIT_CLKS, $urandom_range(20, 300), 0);
            drive(1'b1, $urandom_range(0, 320));
        end

        drive(1'b1, 400);
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_data", {24'd0, rx_data}, {24'd0, last_good});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
